// File: rtl/wrapper_ahb_packet_deconstructor_mc.sv
// wrapper_ahb_packet_deconstructor_mc
// Multi-channel packet buffer drained over AHB-Lite. Each channel holds a small
// FIFO of packets; the head packet of every channel is visible as a word window
// followed by a status/control word. Reading the last word of a head pops it.
module wrapper_ahb_packet_deconstructor_mc #(
    parameter int ADDRWIDTH    = 12,
    parameter int PACKETWIDTH  = 256,
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                hclk,
    input  logic                                hreset,
    input  logic                                hsels,
    input  logic [ADDRWIDTH-1:0]                haddrs,
    input  logic [1:0]                          htranss,
    input  logic [2:0]                          hsizes,
    input  logic                                hwrites,
    input  logic                                hreadys,
    input  logic [31:0]                         hwdatas,
    output logic                                hreadyouts,
    output logic                                hresps,
    output logic [31:0]                         hrdatas,
    input  logic [NUM_CHANNELS*PACKETWIDTH-1:0] packet_data,
    input  logic [NUM_CHANNELS-1:0]             packet_data_last,
    input  logic [NUM_CHANNELS-1:0]             packet_data_valid,
    output logic [NUM_CHANNELS-1:0]             packet_data_ready,
    output logic [NUM_CHANNELS-1:0]             data_avail,
    output logic [NUM_CHANNELS-1:0]             overflow_err
);

    localparam int PKTWORDS = PACKETWIDTH / 32;
    localparam int CHBITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTRW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW     = PTRW + 1;
    localparam int OFFW     = ADDRWIDTH - CHBITS;
    localparam int WIW      = OFFW - 2;
    localparam int WSEL     = (PKTWORDS > 1) ? $clog2(PKTWORDS) : 1;
    localparam int ENTW     = PACKETWIDTH + 1;

    localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(FIFO_DEPTH);
    localparam logic [WIW-1:0]  STATUS_IDX = WIW'(PKTWORDS);
    localparam logic [WSEL-1:0] LAST_WORD  = WSEL'(PKTWORDS - 1);
    localparam logic [CHBITS:0] NCH_LIMIT  = (CHBITS + 1)'(NUM_CHANNELS);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_t;

    // Packet storage: {last, data} per entry
    logic [ENTW-1:0]         mem_r      [NUM_CHANNELS][FIFO_DEPTH];
    logic [PTRW-1:0]         rd_ptr_r   [NUM_CHANNELS];
    logic [PTRW-1:0]         wr_ptr_r   [NUM_CHANNELS];
    logic [CNTW-1:0]         count_r    [NUM_CHANNELS];
    logic [CNTW-1:0]         count_nxt_s[NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_r;

    logic [NUM_CHANNELS-1:0] push_s;
    logic [NUM_CHANNELS-1:0] pop_s;
    logic [NUM_CHANNELS-1:0] flush_s;
    logic [NUM_CHANNELS-1:0] ovf_set_s;
    logic [NUM_CHANNELS-1:0] ovf_clr_s;

    // Address phase decode
    logic              accept_s;
    logic [CHBITS-1:0] addr_ch_s;
    logic [WIW-1:0]    addr_word_s;
    logic              addr_ch_ok_s;
    logic              addr_data_s;
    logic              addr_status_s;
    logic              err_addr_s;

    // Data phase registers
    resp_state_t       state_r;
    logic              hreadyout_r;
    logic              hresp_r;
    logic              dp_valid_r;
    logic              dp_write_r;
    logic              dp_data_r;
    logic              dp_status_r;
    logic [CHBITS-1:0] dp_ch_r;
    logic [WSEL-1:0]   dp_word_r;

    // Read path
    logic [ENTW-1:0]   head_s;
    logic [31:0]       head_words_s [PKTWORDS];
    logic [CNTW-1:0]   dp_count_s;
    logic              dp_empty_s;
    logic [31:0]       status_s;
    logic [31:0]       rdata_s;

    // Bus bits that carry no meaning for this slave
    logic unused_s;
    assign unused_s = ^{hsizes, hwdatas[31:2], htranss[0], haddrs[1:0]};

    // Address-phase decode; no new transfer is taken while the first ERROR cycle stalls the bus
    always_comb begin
        accept_s      = hsels & hreadys & htranss[1] & (state_r != ST_ERR1);
        addr_ch_s     = haddrs[ADDRWIDTH-1 -: CHBITS];
        addr_word_s   = haddrs[OFFW-1:2];
        addr_ch_ok_s  = ({1'b0, addr_ch_s} < NCH_LIMIT);
        addr_data_s   = addr_ch_ok_s & (addr_word_s < STATUS_IDX);
        addr_status_s = addr_ch_ok_s & (addr_word_s == STATUS_IDX);
    end

    // Per-channel push/pop/flush decisions and next occupancy
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            flush_s[c]   = dp_valid_r & dp_write_r & dp_status_r &
                           (dp_ch_r == CHBITS'(c)) & hwdatas[0];
            ovf_clr_s[c] = dp_valid_r & dp_write_r & dp_status_r &
                           (dp_ch_r == CHBITS'(c)) & hwdatas[1];
            pop_s[c]     = dp_valid_r & !dp_write_r & dp_data_r &
                           (dp_ch_r == CHBITS'(c)) & (dp_word_r == LAST_WORD) &
                           (count_r[c] != {CNTW{1'b0}});
            // Flush discards a packet arriving in the same cycle
            push_s[c]    = packet_data_valid[c] & (count_r[c] != FULL_CNT) & !flush_s[c];
            if (flush_s[c]) begin
                count_nxt_s[c] = {CNTW{1'b0}};
            end else begin
                count_nxt_s[c] = count_r[c] + {{(CNTW-1){1'b0}}, push_s[c]}
                                            - {{(CNTW-1){1'b0}}, pop_s[c]};
            end
        end
    end

    // An empty-channel data read is detected one cycle early from the occupancy the data phase will see
    always_comb begin
        err_addr_s = accept_s & !hwrites & addr_data_s &
                     (count_nxt_s[addr_ch_s] == {CNTW{1'b0}});
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ovf_set_s[c] = err_addr_s & (addr_ch_s == CHBITS'(c));
        end
    end

    // Packet storage write port (no reset: contents are only visible when count is non-zero)
    always_ff @(posedge hclk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= {packet_data_last[c],
                                          packet_data[c*PACKETWIDTH +: PACKETWIDTH]};
            end
        end
    end

    // Per-channel FIFO pointers, occupancy and sticky empty-read flags
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_ptr_r[c] <= {PTRW{1'b0}};
                wr_ptr_r[c] <= {PTRW{1'b0}};
                count_r[c]  <= {CNTW{1'b0}};
            end
            ovf_r <= {NUM_CHANNELS{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (flush_s[c]) begin
                    rd_ptr_r[c] <= wr_ptr_r[c];
                end else begin
                    if (push_s[c]) begin
                        wr_ptr_r[c] <= wr_ptr_r[c] + PTRW'(1);
                    end
                    if (pop_s[c]) begin
                        rd_ptr_r[c] <= rd_ptr_r[c] + PTRW'(1);
                    end
                end
                count_r[c] <= count_nxt_s[c];
                // A fresh empty read outranks a clear landing in the same cycle
                if (ovf_set_s[c]) begin
                    ovf_r[c] <= 1'b1;
                end else if (ovf_clr_s[c]) begin
                    ovf_r[c] <= 1'b0;
                end else begin
                    ovf_r[c] <= ovf_r[c];
                end
            end
        end
    end

    // Data-phase capture and OKAY/ERR1/ERR2 response sequencer with registered handshake outputs
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_r     <= ST_OKAY;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_data_r   <= 1'b0;
            dp_status_r <= 1'b0;
            dp_ch_r     <= {CHBITS{1'b0}};
            dp_word_r   <= {WSEL{1'b0}};
        end else begin
            dp_valid_r <= accept_s;
            if (accept_s) begin
                dp_write_r  <= hwrites;
                dp_data_r   <= addr_data_s;
                dp_status_r <= addr_status_s;
                dp_ch_r     <= addr_ch_s;
                dp_word_r   <= addr_word_s[WSEL-1:0];
            end
            case (state_r)
                ST_OKAY, ST_ERR2: begin
                    if (err_addr_s) begin
                        state_r     <= ST_ERR1;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= 1'b1;
                    end else begin
                        state_r     <= ST_OKAY;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_OKAY;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b0;
                end
            endcase
        end
    end

    // Read mux: head word or status of the data-phase channel, zero otherwise
    always_comb begin
        head_s     = mem_r[dp_ch_r][rd_ptr_r[dp_ch_r]];
        dp_count_s = count_r[dp_ch_r];
        dp_empty_s = (dp_count_s == {CNTW{1'b0}});
        for (int w = 0; w < PKTWORDS; w++) begin
            head_words_s[w] = head_s[w*32 +: 32];
        end
        status_s             = 32'h0000_0000;
        status_s[CNTW-1:0]   = dp_count_s;
        status_s[16]         = head_s[PACKETWIDTH] & !dp_empty_s;
        status_s[17]         = dp_empty_s;
        status_s[18]         = ovf_r[dp_ch_r];
        if (dp_valid_r && !dp_write_r) begin
            if (dp_data_r && !dp_empty_s) begin
                rdata_s = head_words_s[dp_word_r];
            end else if (dp_status_r) begin
                rdata_s = status_s;
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Stream-side flags derived from registered occupancy only
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            packet_data_ready[c] = (count_r[c] != FULL_CNT);
            data_avail[c]        = (count_r[c] != {CNTW{1'b0}});
        end
    end

    assign hreadyouts   = hreadyout_r;
    assign hresps       = hresp_r;
    assign hrdatas      = rdata_s;
    assign overflow_err = ovf_r;

endmodule

// File: tb/tb_wrapper_ahb_packet_deconstructor_mc.sv
// Self-checking bench for wrapper_ahb_packet_deconstructor_mc: per-channel packet
// queues model the FIFOs; bus reads are compared against the modelled head packet.
`timescale 1ns/1ps
module tb_wrapper_ahb_packet_deconstructor_mc;

    localparam int AW       = 12;
    localparam int PW       = 256;
    localparam int NCH      = 2;
    localparam int DEPTH    = 4;
    localparam int PKTWORDS = PW / 32;

    typedef logic [PW:0] ent_t;

    logic                hclk = 1'b0;
    logic                hreset;
    logic                hsels;
    logic [AW-1:0]       haddrs;
    logic [1:0]          htranss;
    logic [2:0]          hsizes;
    logic                hwrites;
    logic                hreadys;
    logic [31:0]         hwdatas;
    logic                hreadyouts;
    logic                hresps;
    logic [31:0]         hrdatas;
    logic [NCH*PW-1:0]   packet_data;
    logic [NCH-1:0]      packet_data_last;
    logic [NCH-1:0]      packet_data_valid;
    logic [NCH-1:0]      packet_data_ready;
    logic [NCH-1:0]      data_avail;
    logic [NCH-1:0]      overflow_err;

    ent_t mq [NCH][$];
    logic mov [NCH];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 hclk = ~hclk;

    wrapper_ahb_packet_deconstructor_mc #(
        .ADDRWIDTH(AW), .PACKETWIDTH(PW), .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsels(hsels), .haddrs(haddrs),
        .htranss(htranss), .hsizes(hsizes), .hwrites(hwrites), .hreadys(hreadys),
        .hwdatas(hwdatas), .hreadyouts(hreadyouts), .hresps(hresps), .hrdatas(hrdatas),
        .packet_data(packet_data), .packet_data_last(packet_data_last),
        .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
        .data_avail(data_avail), .overflow_err(overflow_err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected STATUS word from the model: count, head last, empty, sticky flag
    function automatic logic [31:0] status_exp(input int ch);
        logic [31:0] s;
        s       = 32'h0;
        s[2:0]  = 3'(mq[ch].size());
        s[17]   = (mq[ch].size() == 0);
        if (mq[ch].size() != 0) s[16] = mq[ch][0][PW];
        s[18]   = mov[ch];
        return s;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        for (int i = 0; i < PKTWORDS; i++) e[i*32 +: 32] = $urandom;
        e[PW] = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic bus_idle();
        hsels = 1'b0; htranss = 2'b00; hwrites = 1'b0;
    endtask

    task automatic addr_ph(input int ch, input int word, input logic wr);
        hsels = 1'b1; htranss = 2'b10; hwrites = wr; hsizes = 3'b010;
        haddrs = AW'((ch << (AW - 1)) | (word * 4));
    endtask

    task automatic set_pkt(input int ch, input ent_t e);
        packet_data[ch*PW +: PW] = e[PW-1:0];
        packet_data_last[ch]     = e[PW];
    endtask

    // Single read; returns first data-phase sample, rides out an ERROR second cycle
    task automatic rd(input int ch, input int word, output logic [31:0] d,
                      output logic rdy, output logic rsp);
        @(negedge hclk); addr_ph(ch, word, 1'b0);
        @(negedge hclk); bus_idle();
        d = hrdatas; rdy = hreadyouts; rsp = hresps;
        if (!rdy) @(negedge hclk);
    endtask

    // Single write; returns after the data-phase clock edge has taken effect
    task automatic wr(input int ch, input int word, input logic [31:0] data,
                      output logic rdy, output logic rsp);
        @(negedge hclk); addr_ph(ch, word, 1'b1);
        @(negedge hclk); bus_idle(); hwdatas = data;
        rdy = hreadyouts; rsp = hresps;
        @(negedge hclk);
    endtask

    task automatic rd_pkt(input int ch, output logic [PW-1:0] p, output logic err);
        logic [31:0] d; logic rdy, rsp;
        err = 1'b0;
        for (int w = 0; w < PKTWORDS; w++) begin
            rd(ch, w, d, rdy, rsp);
            p[w*32 +: 32] = d;
            if (!rdy || rsp) err = 1'b1;
        end
    endtask

    task automatic push(input int ch, input ent_t e, output bit ok);
        @(negedge hclk); set_pkt(ch, e); packet_data_valid[ch] = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (packet_data_ready[ch]) ok = 1'b1;
            @(negedge hclk);
        end
        packet_data_valid[ch] = 1'b0;
        if (ok) mq[ch].push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        n_checks++; if ({hreadyouts, hresps, hrdatas} !== {1'b1, 1'b0, 32'h0}) begin n_fail++;
            $display("FAIL reset_bus: got rdy=%b resp=%b data=%h expected 1 0 0", hreadyouts, hresps, hrdatas); end
        n_checks++; if ({packet_data_ready, data_avail, overflow_err} !== {2'b11, 2'b00, 2'b00}) begin n_fail++;
            $display("FAIL reset_flags: got ready=%b avail=%b ovf=%b expected 11 00 00", packet_data_ready, data_avail, overflow_err); end
        // Empty read to reach ERR1, then reset in the middle of it
        addr_ph(0, 2, 1'b0);
        @(negedge hclk); bus_idle();
        n_checks++; if (hreadyouts !== 1'b0) begin n_fail++;
            $display("FAIL reset_err1_entry: got hreadyouts=%b expected 0", hreadyouts); end
        hreset = 1'b1;
        #1;
        n_checks++; if ({hreadyouts, hresps, packet_data_ready, data_avail, overflow_err} !== {1'b1, 1'b0, 2'b11, 2'b00, 2'b00}) begin n_fail++;
            $display("FAIL reset_mid_err: got rdy=%b resp=%b ready=%b avail=%b ovf=%b expected 1 0 11 00 00",
                     hreadyouts, hresps, packet_data_ready, data_avail, overflow_err); end
        @(negedge hclk); hreset = 1'b0;
        d = hrdatas;
        n_checks++; if ({hreadyouts, hresps, d} !== {1'b1, 1'b0, 32'h0}) begin n_fail++;
            $display("FAIL reset_after: got rdy=%b resp=%b data=%h expected 1 0 0", hreadyouts, hresps, d); end
    endtask

    task automatic test_basic();
        ent_t e; bit ok; logic [31:0] d, exp; logic rdy, rsp;
        e = rand_ent(); e[31:0] = 32'h3; e[63:32] = 32'h7; e[PW] = 1'b1;
        push(1, e, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_push: got ok=0 expected 1"); end
        rd(1, PKTWORDS, d, rdy, rsp);
        n_checks++; if (d !== 32'h0001_0001) begin n_fail++;
            $display("FAIL basic_status: got %h expected %h", d, 32'h0001_0001); end
        for (int w = 0; w < PKTWORDS; w++) begin
            rd(1, w, d, rdy, rsp);
            exp = e[w*32 +: 32];
            n_checks++; if ({d, rdy, rsp} !== {exp, 1'b1, 1'b0}) begin n_fail++;
                $display("FAIL basic_word%0d: got %h rdy=%b resp=%b expected %h 1 0", w, d, rdy, rsp, exp); end
        end
        mq[1].pop_front();
        @(negedge hclk);
        n_checks++; if (data_avail !== 2'b00) begin n_fail++;
            $display("FAIL basic_avail: got %b expected 00", data_avail); end
        rd(1, PKTWORDS, d, rdy, rsp);
        n_checks++; if ((d & 32'hFFFE_FFFF) !== 32'h0002_0000) begin n_fail++;
            $display("FAIL basic_status_empty: got %h expected %h", d, 32'h0002_0000); end
    endtask

    task automatic test_fill();
        ent_t e, e5; bit ok; logic [31:0] d; logic rdy, rsp; logic [PW-1:0] p; logic er;
        for (int i = 0; i < DEPTH; i++) begin
            e = rand_ent(); push(0, e, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_push%0d: got ok=0 expected 1", i); end
        end
        n_checks++; if (packet_data_ready !== 2'b10) begin n_fail++;
            $display("FAIL fill_ready_full: got %b expected 10", packet_data_ready); end
        e5 = rand_ent(); set_pkt(0, e5); packet_data_valid[0] = 1'b1;
        repeat (2) @(negedge hclk);
        rd(0, PKTWORDS, d, rdy, rsp);
        n_checks++; if (d !== status_exp(0)) begin n_fail++;
            $display("FAIL fill_status_held: got %h expected %h", d, status_exp(0)); end
        rd_pkt(0, p, er);
        n_checks++; if ({p, er} !== {mq[0][0][PW-1:0], 1'b0}) begin n_fail++;
            $display("FAIL fill_head: got %h err=%b expected %h", p, er, mq[0][0][PW-1:0]); end
        mq[0].pop_front();
        @(negedge hclk);
        n_checks++; if (packet_data_ready[0] !== 1'b1) begin n_fail++;
            $display("FAIL fill_ready_after_pop: got %b expected 1", packet_data_ready[0]); end
        @(negedge hclk); packet_data_valid[0] = 1'b0; mq[0].push_back(e5);
        n_checks++; if ({packet_data_ready, data_avail} !== {2'b10, 2'b01}) begin n_fail++;
            $display("FAIL fill_refull: got ready=%b avail=%b expected 10 01", packet_data_ready, data_avail); end
        rd(0, PKTWORDS, d, rdy, rsp);
        n_checks++; if (d !== status_exp(0)) begin n_fail++;
            $display("FAIL fill_status4: got %h expected %h", d, status_exp(0)); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_pkt(0, p, er);
            n_checks++; if ({p, er} !== {mq[0][0][PW-1:0], 1'b0}) begin n_fail++;
                $display("FAIL fill_drain%0d: got %h err=%b expected %h", i, p, er, mq[0][0][PW-1:0]); end
            mq[0].pop_front();
        end
    endtask

    task automatic test_empty_err();
        logic [31:0] d, exp; logic rdy, rsp;
        @(negedge hclk); addr_ph(0, 2, 1'b0);
        @(negedge hclk); bus_idle();
        n_checks++; if ({hreadyouts, hresps, hrdatas} !== {1'b0, 1'b1, 32'h0}) begin n_fail++;
            $display("FAIL err_cycle1: got rdy=%b resp=%b data=%h expected 0 1 0", hreadyouts, hresps, hrdatas); end
        @(negedge hclk);
        mov[0] = 1'b1;
        n_checks++; if ({hreadyouts, hresps, hrdatas, overflow_err} !== {1'b1, 1'b1, 32'h0, 2'b01}) begin n_fail++;
            $display("FAIL err_cycle2: got rdy=%b resp=%b data=%h ovf=%b expected 1 1 0 01", hreadyouts, hresps, hrdatas, overflow_err); end
        // Transfer presented during the second ERROR cycle is taken normally
        addr_ph(0, PKTWORDS, 1'b0);
        @(negedge hclk); bus_idle();
        exp = status_exp(0);
        n_checks++; if ({hreadyouts, hresps, hrdatas & 32'hFFFE_FFFF, data_avail} !== {1'b1, 1'b0, exp & 32'hFFFE_FFFF, 2'b00}) begin n_fail++;
            $display("FAIL err_b2b_status: got rdy=%b resp=%b data=%h avail=%b expected 1 0 %h 00", hreadyouts, hresps, hrdatas, data_avail, exp); end
        wr(0, PKTWORDS, 32'h2, rdy, rsp);
        mov[0] = 1'b0;
        n_checks++; if ({rdy, rsp, overflow_err} !== {1'b1, 1'b0, 2'b00}) begin n_fail++;
            $display("FAIL err_clear: got rdy=%b resp=%b ovf=%b expected 1 0 00", rdy, rsp, overflow_err); end
        rd(0, PKTWORDS, d, rdy, rsp);
        n_checks++; if ((d & 32'hFFFE_FFFF) !== (status_exp(0) & 32'hFFFE_FFFF)) begin n_fail++;
            $display("FAIL err_status_cleared: got %h expected %h", d, status_exp(0)); end
    endtask

    task automatic test_flush();
        ent_t e; bit ok; logic [31:0] d; logic rdy, rsp; logic [PW-1:0] p; logic er;
        for (int i = 0; i < 2; i++) begin
            e = rand_ent(); push(0, e, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_push%0d: got ok=0 expected 1", i); end
        end
        @(negedge hclk); addr_ph(0, PKTWORDS, 1'b1);
        @(negedge hclk); bus_idle(); hwdatas = 32'h1;
        e = rand_ent(); set_pkt(0, e); packet_data_valid[0] = 1'b1;
        @(negedge hclk); packet_data_valid[0] = 1'b0;
        mq[0].delete();
        n_checks++; if ({data_avail[0], packet_data_ready[0]} !== 2'b01) begin n_fail++;
            $display("FAIL flush_flags: got avail=%b ready=%b expected 0 1", data_avail[0], packet_data_ready[0]); end
        rd(0, PKTWORDS, d, rdy, rsp);
        n_checks++; if ((d & 32'hFFFE_FFFF) !== 32'h0002_0000) begin n_fail++;
            $display("FAIL flush_status: got %h expected %h", d, 32'h0002_0000); end
        e = rand_ent(); push(0, e, ok);
        rd_pkt(0, p, er);
        n_checks++; if ({p, er} !== {e[PW-1:0], 1'b0}) begin n_fail++;
            $display("FAIL flush_next_pkt: got %h err=%b expected %h", p, er, e[PW-1:0]); end
        mq[0].pop_front();
    endtask

    task automatic test_wrap();
        ent_t e, en; bit ok; logic [31:0] d; logic rdy, rsp, er; logic [PW-1:0] p;
        e = rand_ent(); push(1, e, ok);
        for (int it = 0; it < 10; it++) begin
            er = 1'b0;
            for (int w = 0; w < PKTWORDS - 1; w++) begin
                rd(1, w, d, rdy, rsp);
                p[w*32 +: 32] = d;
                if (!rdy || rsp) er = 1'b1;
            end
            @(negedge hclk); addr_ph(1, PKTWORDS - 1, 1'b0);
            @(negedge hclk); bus_idle();
            p[PW-32 +: 32] = hrdatas;
            if (!hreadyouts || hresps) er = 1'b1;
            en = rand_ent(); set_pkt(1, en); packet_data_valid[1] = 1'b1;
            @(negedge hclk); packet_data_valid[1] = 1'b0;
            n_checks++; if ({p, er} !== {mq[1][0][PW-1:0], 1'b0}) begin n_fail++;
                $display("FAIL wrap_pkt%0d: got %h err=%b expected %h", it, p, er, mq[1][0][PW-1:0]); end
            mq[1].pop_front(); mq[1].push_back(en);
            rd(1, PKTWORDS, d, rdy, rsp);
            n_checks++; if (d !== status_exp(1)) begin n_fail++;
                $display("FAIL wrap_status%0d: got %h expected %h", it, d, status_exp(1)); end
        end
        rd_pkt(1, p, er);
        n_checks++; if ({p, er} !== {mq[1][0][PW-1:0], 1'b0}) begin n_fail++;
            $display("FAIL wrap_last: got %h err=%b expected %h", p, er, mq[1][0][PW-1:0]); end
        mq[1].pop_front();
    endtask

    task automatic test_random();
        int ch; bit ok; logic [31:0] d, exp; logic rdy, rsp, er; logic [PW-1:0] p;
        for (int i = 0; i < 40; i++) begin
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 1) == 1 && mq[ch].size() < DEPTH) begin
                push(ch, rand_ent(), ok);
                n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_push%0d: got ok=0 expected 1", i); end
            end else if (mq[ch].size() > 0) begin
                rd_pkt(ch, p, er);
                n_checks++; if ({p, er} !== {mq[ch][0][PW-1:0], 1'b0}) begin n_fail++;
                    $display("FAIL rand_pkt%0d: got %h err=%b expected %h", i, p, er, mq[ch][0][PW-1:0]); end
                mq[ch].pop_front();
            end else begin
                rd(ch, PKTWORDS, d, rdy, rsp);
                exp = status_exp(ch);
                n_checks++; if ((d & 32'hFFFE_FFFF) !== (exp & 32'hFFFE_FFFF)) begin n_fail++;
                    $display("FAIL rand_status%0d: got %h expected %h", i, d, exp); end
            end
        end
    endtask

    initial begin
        hreset = 1'b1; bus_idle(); haddrs = '0; hsizes = 3'b010; hreadys = 1'b1;
        hwdatas = 32'h0; packet_data = '0; packet_data_last = '0; packet_data_valid = '0;
        foreach (mov[i]) mov[i] = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_empty_err();
        test_flush();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
